integral_window: RTL and testbench

INTEGRAL_WINDOW -- requirements
Module: integral_window

---
 rtl/integral_window_if.sv | 28 ++
 rtl/integral_window.sv | 125 ++++++++++++
 tb/tb_integral_window.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/integral_window_if.sv
// Pixel/control/readback bundle between an integral_window and its driver.
interface integral_window_if #(
  parameter int PIX_W  = 8,
  parameter int SUM_W  = 32,
  parameter int ADDR_W = 9
);
  logic              START;
  logic              ABORT;
  logic              PIX_VALID;
  logic              PIX_READY;
  logic [PIX_W-1:0]  VGA_R_in;
  logic [PIX_W-1:0]  VGA_G_in;
  logic [PIX_W-1:0]  VGA_B_in;
  logic              BUSY;
  logic              DONE;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [SUM_W-1:0]  RD_DATA;

  modport master (
    output START, ABORT, PIX_VALID, VGA_R_in, VGA_G_in, VGA_B_in, RD_ADDR,
    input  PIX_READY, BUSY, DONE, RD_DATA
  );

  modport slave (
    input  START, ABORT, PIX_VALID, VGA_R_in, VGA_G_in, VGA_B_in, RD_ADDR,
    output PIX_READY, BUSY, DONE, RD_DATA
  );
endinterface

// File: rtl/integral_window.sv
// Builds a WIN_W x WIN_H integral image from a raster pixel stream; one pixel per cycle when ready,
// readback has 1-cycle latency and is valid only in DONE.
module integral_window #(
  parameter int WIN_W = 20,
  parameter int WIN_H = 20,
  parameter int PIX_W = 8,
  parameter int SUM_W = 32,
  parameter int MODE  = 0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  integral_window_if.slave bus
);
  localparam int NPIX   = WIN_W * WIN_H;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int XW     = $clog2(WIN_W);
  localparam int YW     = $clog2(WIN_H);
  localparam int LW     = PIX_W + 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Assert asynchronously, release two edges after RESET_N rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SUM_W-1:0]  rs_q, rs_d, ii_d;
  logic [SUM_W-1:0]  rd_q, rd_d;
  logic [SUM_W-1:0]  mem [NPIX];
  logic [SUM_W-1:0]  lb  [WIN_W];
  logic              accept, last, restart, rd_ok;
  logic [LW-1:0]     luma;
  logic [PIX_W-1:0]  gray;

  always_comb begin
    luma = LW'(bus.VGA_R_in) * LW'(77) + LW'(bus.VGA_G_in) * LW'(150)
         + LW'(bus.VGA_B_in) * LW'(29);
    gray = (MODE == 1) ? bus.VGA_G_in : PIX_W'(luma >> 8);
  end

  always_comb begin
    last    = (x_q == XW'(WIN_W - 1)) && (y_q == YW'(WIN_H - 1));
    restart = bus.START && !bus.ABORT && (state_q != S_ACCUM);
    accept  = bus.PIX_VALID && (state_q == S_ACCUM) && !bus.ABORT;
    rs_d    = ((x_q == '0) ? '0 : rs_q) + SUM_W'(gray);
    // Line buffer holds the row above at the same x, so the store needs one port only.
    ii_d    = rs_d + ((y_q == '0) ? '0 : lb[x_q]);

    state_d = state_q;
    if (bus.ABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.START)     state_d = S_ACCUM;
        S_ACCUM: if (accept && last) state_d = S_DONE;
        S_DONE:  if (bus.START)     state_d = S_ACCUM;
        default:                    state_d = S_IDLE;
      endcase
    end

    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (restart) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (accept) begin
      addr_d = addr_q + ADDR_W'(1);
      if (x_q == XW'(WIN_W - 1)) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    // Gate on the next state too, so ABORT/START in DONE zero the readback at once.
    rd_ok = (state_q == S_DONE) && (state_d == S_DONE)
         && ({1'b0, bus.RD_ADDR} < (ADDR_W + 1)'(NPIX));
    rd_d  = rd_ok ? mem[bus.RD_ADDR] : '0;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      rs_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      if (restart)     rs_q <= '0;
      else if (accept) rs_q <= rs_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[addr_q] <= ii_d;
      lb[x_q]     <= ii_d;
    end
  end

  assign bus.PIX_READY = (state_q == S_ACCUM);
  assign bus.BUSY      = (state_q == S_ACCUM);
  assign bus.DONE      = (state_q == S_DONE);
  assign bus.RD_DATA   = rd_q;
endmodule

// File: tb/tb_integral_window.sv
// Two instances: 4x4 G-only window and 20x20 luma window, checked against a direct double-sum model.
module tb_integral_window;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0, abort_r = 1'b0, pv_r = 1'b0;
  logic [7:0] r_r = '0, g_r = '0, b_r = '0;
  logic [8:0] rd_addr = '0;
  int         sel = 0;

  integral_window_if #(.PIX_W(8), .SUM_W(32), .ADDR_W(4)) if0();
  integral_window_if #(.PIX_W(8), .SUM_W(32), .ADDR_W(9)) if1();

  assign if0.START = start0;   assign if1.START = start1;
  assign if0.ABORT = abort_r;  assign if1.ABORT = abort_r;
  assign if0.PIX_VALID = pv_r; assign if1.PIX_VALID = pv_r;
  assign if0.VGA_R_in = r_r;   assign if1.VGA_R_in = r_r;
  assign if0.VGA_G_in = g_r;   assign if1.VGA_G_in = g_r;
  assign if0.VGA_B_in = b_r;   assign if1.VGA_B_in = b_r;
  assign if0.RD_ADDR = rd_addr[3:0];
  assign if1.RD_ADDR = rd_addr;

  integral_window #(.WIN_W(4),  .WIN_H(4),  .PIX_W(8), .SUM_W(32), .MODE(1))
    u0 (.CLK(clk), .RESET_N(rst_n), .bus(if0));
  integral_window #(.WIN_W(20), .WIN_H(20), .PIX_W(8), .SUM_W(32), .MODE(0))
    u1 (.CLK(clk), .RESET_N(rst_n), .bus(if1));

  logic        s_ready, s_busy, s_done;
  logic [31:0] s_rd;
  always_comb begin
    if (sel == 0) begin
      s_ready = if0.PIX_READY; s_busy = if0.BUSY; s_done = if0.DONE; s_rd = if0.RD_DATA;
    end else begin
      s_ready = if1.PIX_READY; s_busy = if1.BUSY; s_done = if1.DONE; s_rd = if1.RD_DATA;
    end
  end

  int          total = 0;
  int          bad   = 0;
  int          gry [400];
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int win_w();
    return (sel == 0) ? 4 : 20;
  endfunction

  function automatic int gray_of(input int r, input int g, input int b);
    if (sel == 0) return g;
    return ((77 * r + 150 * g + 29 * b) >> 8) & 255;
  endfunction

  function automatic logic [31:0] ii_ref(input int k);
    int w = win_w();
    int s = 0;
    for (int j = 0; j <= k / w; j++)
      for (int i = 0; i <= k % w; i++)
        s += gry[j * w + i];
    return 32'(s);
  endfunction

  task automatic start_win();
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    chk("start_busy", 32'(s_busy), 32'd1);
    chk("start_done", 32'(s_done), 32'd0);
  endtask

  // pat: 0 G=1, 1 all 255, 2 (x+y)&255 on every channel, 3 random
  task automatic feed(input int n, input int pat, input int gap, input int hold);
    int acc = 0;
    int cyc = 0;
    int w = win_w();
    int v;
    while (acc < n && cyc < 20 * n + 100) begin
      v = ((acc % w) + (acc / w)) & 255;
      case (pat)
        0: begin r_r = 8'd0; g_r = 8'd1; b_r = 8'd0; end
        1: begin r_r = 8'd255; g_r = 8'd255; b_r = 8'd255; end
        2: begin r_r = 8'(v); g_r = 8'(v); b_r = 8'(v); end
        default: begin
          r_r = 8'($urandom_range(255)); g_r = 8'($urandom_range(255)); b_r = 8'($urandom_range(255));
        end
      endcase
      pv_r = ($urandom_range(99) >= gap);
      if (sel == 0) start0 = (acc < hold); else start1 = (acc < hold);
      if (pv_r && s_ready) begin
        gry[acc] = gray_of(int'(r_r), int'(g_r), int'(b_r));
        exp_q.push_back(ii_ref(acc));
        if (acc == w * w - 1) chk("done_pre", 32'(s_done), 32'd0);
        acc++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    pv_r = 1'b0; start0 = 1'b0; start1 = 1'b0;
    if (acc < n) begin
      chk("feed_timeout", 32'(acc), 32'(n));
    end else if (n == w * w) begin
      chk("done_rise", 32'(s_done), 32'd1);
      chk("done_busy", 32'(s_busy), 32'd0);
      chk("done_ready", 32'(s_ready), 32'd0);
    end
  endtask

  task automatic rd_chk(input int a, input logic [31:0] exp, input string tag);
    rd_addr = 9'(a);
    @(posedge clk); @(negedge clk);
    chk(tag, s_rd, exp);
  endtask

  task automatic drain(input int n);
    logic [31:0] e;
    for (int a = 0; a < n; a++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      rd_chk(a, e, $sformatf("ii[%0d] sel%0d", a, sel));
    end
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      chk("rst_ready", 32'(s_ready), 32'd0);
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_done", 32'(s_done), 32'd0);
      chk("rst_rd", s_rd, 32'd0);
    end
    sel = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 4x4 G-only window, continuous valid
    rd_chk(5, 32'd0, "idle_rd");
    start_win();
    feed(16, 0, 0, 0);
    drain(16);
    rd_chk(15, 32'd16, "g1_ii15");
    rd_chk(5, 32'd4, "g1_ii5");

    // ABORT from DONE zeroes readback and DONE together
    abort_r = 1'b1;
    @(posedge clk); @(negedge clk);
    abort_r = 1'b0;
    chk("abort_done_rd", s_rd, 32'd0);
    chk("abort_done_done", 32'(s_done), 32'd0);

    // ABORT coinciding with the 7th accept
    start_win();
    feed(6, 3, 0, 0);
    pv_r = 1'b1; abort_r = 1'b1;
    chk("abort_pre_ready", 32'(s_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    pv_r = 1'b0; abort_r = 1'b0;
    chk("abort_busy", 32'(s_busy), 32'd0);
    chk("abort_done", 32'(s_done), 32'd0);
    chk("abort_ready", 32'(s_ready), 32'd0);
    exp_q.delete();
    rd_chk(0, 32'd0, "abort_rd");

    // fresh window with gaps while START is held during ACCUM
    start_win();
    feed(16, 3, 30, 5);
    drain(16);

    // START in DONE: new window replaces old contents
    start_win();
    feed(16, 2, 0, 0);
    drain(16);

    // 20x20 luma window
    sel = 1; #1;
    chk("idle_ready20", 32'(s_ready), 32'd0);
    @(negedge clk);
    start_win();
    feed(400, 1, 0, 0);
    exp_q.delete();
    rd_chk(15, 32'd4080, "w255_ii15");
    rd_chk(20, 32'd510, "w255_ii20");
    rd_chk(399, 32'd102000, "w255_ii399");
    rd_chk(400, 32'd0, "oob_400");
    rd_chk(511, 32'd0, "oob_511");

    start_win();
    feed(400, 2, 40, 0);
    drain(400);
    chk("done_ready20", 32'(s_ready), 32'd0);

    // reset mid-window
    start_win();
    feed(50, 2, 0, 0);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(s_busy), 32'd0);
    chk("arst_ready", 32'(s_ready), 32'd0);
    chk("arst_done", 32'(s_done), 32'd0);
    chk("arst_rd", s_rd, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    start1 = 1'b1;
    @(posedge clk); @(negedge clk);
    start1 = 1'b0;
    chk("early_start", 32'(s_busy), 32'd0);
    repeat (2) @(negedge clk);
    start_win();
    feed(400, 3, 20, 0);
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
